// File: rtl/mbox_if.sv
// mbox bus port bundle
// crossbar master drives requests, mailbox answers
interface mbox_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_resp;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_be, bus_wdata,
    input  bus_ack, bus_resp, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_be, bus_wdata,
    output bus_ack, bus_resp, bus_rdata
  );
endinterface

// File: rtl/mbox.sv
// mbox: inter-tile mailbox, 32-bit word FIFO
// on the crossbar bus with threshold interrupt
module mbox #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  mbox_if.slave bus,
  output logic irq_o
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic [CW-1:0] thr, thr_n, thr_eff;
  logic          irq_en, irq_en_n;
  logic          ovf, udf;
  logic          resp_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   wdata_m, status;
  logic [1:0]    sel;
  logic          wr, rd, empty, full;
  logic          push, drop, pop, under;
  logic          flush, clr, ctrl_we, thr_we;
  logic          unused;

  assign unused = ^{bus.bus_addr[31:4], bus.bus_addr[1:0]};

  assign sel   = bus.bus_addr[3:2];
  assign wr    = bus.bus_req & bus.bus_we;
  assign rd    = bus.bus_req & ~bus.bus_we;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign push  = wr & (sel == 2'd0) & (|bus.bus_be) & ~full;
  assign drop  = wr & (sel == 2'd0) & (|bus.bus_be) & full;
  assign pop   = rd & (sel == 2'd0) & ~empty;
  assign under = rd & (sel == 2'd0) & empty;

  assign ctrl_we = wr & (sel == 2'd2) & bus.bus_be[0];
  assign thr_we  = wr & (sel == 2'd3) & bus.bus_be[0];
  assign flush   = ctrl_we & bus.bus_wdata[1];
  assign clr     = ctrl_we & bus.bus_wdata[2];

  assign wdata_m = {
    bus.bus_be[3] ? bus.bus_wdata[31:24] : 8'h00,
    bus.bus_be[2] ? bus.bus_wdata[23:16] : 8'h00,
    bus.bus_be[1] ? bus.bus_wdata[15:8]  : 8'h00,
    bus.bus_be[0] ? bus.bus_wdata[7:0]   : 8'h00
  };

  // post-update state used for count and irq
  always_comb begin
    count_n  = count + CW'(push) - CW'(pop);
    irq_en_n = irq_en;
    thr_n    = thr;
    if (flush)   count_n  = '0;
    if (ctrl_we) irq_en_n = bus.bus_wdata[0];
    if (thr_we)  thr_n    = bus.bus_wdata[CW-1:0];
    thr_eff = (thr_n == '0) ? CW'(1) : thr_n;
  end

  // read mux over pre-update state
  always_comb begin
    status             = '0;
    status[CW-1:0]     = count;
    status[16]         = empty;
    status[17]         = full;
    status[18]         = ovf;
    status[19]         = udf;
    rdata_d            = '0;
    case (sel)
      2'd0: rdata_d = empty ? '0 : mem[rd_ptr];
      2'd1: rdata_d = status;
      2'd2: rdata_d = {31'd0, irq_en};
      default: rdata_d = {{(32-CW){1'b0}}, thr};
    endcase
  end

  // FIFO storage, written at the end of the accept cycle
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem[wr_ptr] <= wdata_m;
  end

  // pointers, count, control and sticky flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      irq_en <= 1'b0;
      thr    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      count  <= count_n;
      irq_en <= irq_en_n;
      thr    <= thr_n;
      irq_o  <= irq_en_n & (count_n >= thr_eff);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (drop)  ovf <= 1'b1;
        if (under) udf <= 1'b1;
      end
    end
  end

  // one-cycle read response, data held until next read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= rd;
      if (rd) rdata_q <= rdata_d;
    end
  end

  assign bus.bus_ack   = bus.bus_req;
  assign bus.bus_resp  = resp_q & ~rst_i;
  assign bus.bus_rdata = rdata_q;
endmodule

// File: tb/tb_mbox.sv
// tb_mbox: scoreboard bench for mbox
// reads queue expected data, monitor pops on resp
module tb_mbox;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   n_chk = 0;
  int   n_fail = 0;
  logic rd_acc = 1'b0;
  logic [31:0] sb_q [$];

  mbox_if b ();

  mbox dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk) #1;
    b.bus_req   = 1'b0;
    b.bus_we    = 1'b0;
    b.bus_be    = 4'h0;
  endtask

  task automatic wr(
    input logic [1:0]  a,
    input logic [31:0] d,
    input logic [3:0]  be = 4'hf
  );
    @(posedge clk) #1;
    b.bus_req   = 1'b1;
    b.bus_we    = 1'b1;
    b.bus_addr  = {28'd0, a, 2'b00};
    b.bus_be    = be;
    b.bus_wdata = d;
  endtask

  task automatic rd(
    input logic [1:0]  a,
    input logic [31:0] exp
  );
    @(posedge clk) #1;
    b.bus_req   = 1'b1;
    b.bus_we    = 1'b0;
    b.bus_addr  = {28'd0, a, 2'b00};
    b.bus_be    = 4'hf;
    b.bus_wdata = 32'hdead_beef;
    sb_q.push_back(exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    idle();
    @(negedge clk);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // read accepted at the last edge, so a resp is due now
  always @(posedge clk)
    rd_acc <= b.bus_req & ~b.bus_we & ~rst;

  // response timing and scoreboard compare
  always @(negedge clk) begin
    check("ack", {31'd0, b.bus_ack}, {31'd0, b.bus_req});
    check("resp", {31'd0, b.bus_resp},
          {31'd0, rd_acc & ~rst});
    if (b.bus_resp) begin
      if (sb_q.size() == 0)
        check("resp_unexp", 32'd1, 32'd0);
      else
        check("rdata", b.bus_rdata, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    b.bus_req   = 1'b0;
    b.bus_we    = 1'b0;
    b.bus_addr  = '0;
    b.bus_be    = '0;
    b.bus_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", b.bus_rdata, 32'd0);
    check("rst_resp", {31'd0, b.bus_resp}, 32'd0);

    rd(2'd1, 32'h0001_0000);

    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    wr(2'd0, 32'h33);
    rd(2'd0, 32'h11);
    rd(2'd0, 32'h22);
    rd(2'd0, 32'h33);
    rd(2'd1, 32'h0001_0000);

    for (int i = 0; i < 17; i++) wr(2'd0, i);
    rd(2'd1, 32'h0006_0010);
    for (int i = 0; i < 16; i++) rd(2'd0, i);
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h000d_0000);
    wr(2'd2, 32'h4);
    rd(2'd1, 32'h0001_0000);
    rd(2'd2, 32'h0);

    wr(2'd3, 32'h3);
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h1);
    rd(2'd3, 32'h3);
    wr(2'd0, 32'ha1);
    wr(2'd0, 32'ha2);
    chk_irq("irq_2of3", 1'b0);
    wr(2'd0, 32'ha3);
    chk_irq("irq_3of3", 1'b1);
    rd(2'd0, 32'ha1);
    chk_irq("irq_pop", 1'b0);
    rd(2'd0, 32'ha2);
    chk_irq("irq_1of3", 1'b0);
    wr(2'd3, 32'h0);
    chk_irq("irq_thr0", 1'b1);
    rd(2'd0, 32'ha3);
    chk_irq("irq_empty", 1'b0);
    wr(2'd2, 32'h0);
    rd(2'd3, 32'h0);

    wr(2'd0, 32'haabb_ccdd, 4'b0101);
    wr(2'd0, 32'h0000_0123, 4'b0000);
    wr(2'd1, 32'hffff_ffff);
    rd(2'd1, 32'h0000_0001);
    rd(2'd0, 32'h00bb_00dd);
    rd(2'd1, 32'h0001_0000);

    wr(2'd0, 32'h5);
    wr(2'd0, 32'h6);
    wr(2'd2, 32'h2);
    rd(2'd1, 32'h0001_0000);
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h0009_0000);
    wr(2'd2, 32'h4);

    wr(2'd0, 32'h7);
    wr(2'd0, 32'h8);
    rd(2'd0, 32'h7);
    rd(2'd1, 32'h0000_0001);
    rd(2'd0, 32'h8);

    for (int i = 0; i < 40; i++) begin
      wr(2'd0, 32'h100 + i);
      rd(2'd0, 32'h100 + i);
    end
    rd(2'd1, 32'h0001_0000);

    wr(2'd2, 32'h1);
    wr(2'd0, 32'h9);
    wr(2'd0, 32'ha);
    rd(2'd0, 32'h9);
    @(posedge clk) #1;
    rst = 1'b1;
    b.bus_req = 1'b1;
    b.bus_we  = 1'b1;
    b.bus_addr = 32'h0;
    sb_q.delete();
    @(posedge clk) #1;
    rst = 1'b0;
    b.bus_req = 1'b0;
    @(negedge clk);
    check("rst2_irq", {31'd0, irq}, 32'd0);
    rd(2'd1, 32'h0001_0000);
    rd(2'd2, 32'h0);
    idle();
    repeat (3) @(negedge clk);
    check("sb_drain", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
